// File: rtl/ov7725_capture_ctrl_pkg.sv
// Shared types and codes for the OV7725 capture controller: FSM states,
// decimation select codes and capture modes.
package ov7725_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } cap_state_t;

  localparam logic [1:0] DECIM_1 = 2'b00;
  localparam logic [1:0] DECIM_2 = 2'b01;
  localparam logic [1:0] DECIM_4 = 2'b10;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  // Decimation factors are powers of two, so the window logic works in shifts.
  function automatic logic [1:0] decim_shift(input logic [1:0] sel);
    logic [1:0] sh;
    case (sel)
      DECIM_1: sh = 2'd0;
      DECIM_2: sh = 2'd1;
      default: sh = 2'd2;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/ov7725_capture_ctrl_if.sv
// frame_buffer port A write bus: address, RGB565 pixel and write strobe.
interface ov7725_capture_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic [ADDR_W-1:0] addr;
  logic [15:0]       dout;
  logic              we;

  modport master (output addr, output dout, output we);
  modport slave  (input  addr, input  dout, input  we);
endinterface

// File: rtl/ov7725_capture_ctrl_pixel_pack.sv
// Pairs registered DVP bytes into RGB565 pixels and flags lines that end on
// an odd byte count.
module ov7725_capture_ctrl_pixel_pack (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        href,
  input  logic [7:0]  d,
  output logic        pix_valid,
  output logic [15:0] pix,
  output logic        err_odd
);
  logic       phase;
  logic [7:0] hi_byte;

  assign pix_valid = href & phase;
  assign pix       = {hi_byte, d};

  // A phase still set when href drops means the low byte never came; the
  // held high byte is simply abandoned.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 1'b0;
      hi_byte <= 8'd0;
      err_odd <= 1'b0;
    end else if (!href) begin
      phase <= 1'b0;
      if (phase) err_odd <= 1'b1;
    end else begin
      phase <= ~phase;
      if (!phase) hi_byte <= d;
    end
  end

endmodule

// File: rtl/ov7725_capture_ctrl.sv
// OV7725 capture path: crops and decimates the sensor pixel stream into the
// frame_buffer, with continuous or single-shot (freeze) frame sequencing.
module ov7725_capture_ctrl
  import ov7725_capture_ctrl_pkg::*;
#(
  parameter int OUT_W  = 320,
  parameter int OUT_H  = 240,
  parameter int ADDR_W = 17,
  parameter int SRC_W  = 640
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [7:0]            d,
  input  logic                  mode,
  input  logic                  arm,
  input  logic [1:0]            decim_sel,
  input  logic [9:0]            x_start,
  input  logic [8:0]            y_start,
  ov7725_capture_ctrl_if.master fb,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            frame_cnt,
  output logic                  err_odd,
  output logic                  err_long
);
  localparam int CW = 12;
  localparam logic [CW-1:0]     OUT_W_C   = CW'(OUT_W);
  localparam logic [CW-1:0]     OUT_H_C   = CW'(OUT_H);
  localparam logic [CW-1:0]     SRC_W_C   = CW'(SRC_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_W * OUT_H - 1);

  cap_state_t state, state_nx;
  logic        vsync_r, vsync_q, href_r, href_q, arm_r, arm_q;
  logic [7:0]  d_r;
  logic        vs_rise, href_fall, arm_edge, frame_end;
  logic        pix_valid, in_win, keep, full;
  logic [15:0] pix, dout_q;
  logic [CW-1:0] x_cnt, y_cnt, dx, dy, mask;
  logic [9:0]  xs_s;
  logic [8:0]  ys_s;
  logic [1:0]  shift_s;
  logic [ADDR_W-1:0] wr_ptr, addr_q;
  logic        we_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r <= 1'b0; vsync_q <= 1'b0;
      href_r  <= 1'b0; href_q  <= 1'b0;
      arm_r   <= 1'b0; arm_q   <= 1'b0;
      d_r     <= 8'd0;
    end else begin
      vsync_r <= vsync; vsync_q <= vsync_r;
      href_r  <= href;  href_q  <= href_r;
      arm_r   <= arm;   arm_q   <= arm_r;
      d_r     <= d;
    end
  end

  assign vs_rise   = vsync_r & ~vsync_q;
  assign href_fall = href_q & ~href_r;
  assign arm_edge  = arm_r & ~arm_q;

  ov7725_capture_ctrl_pixel_pack u_pack (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .href      (href_r),
    .d         (d_r),
    .pix_valid (pix_valid),
    .pix       (pix),
    .err_odd   (err_odd)
  );

  // Window settings only move at frame start so a frame is never torn.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      xs_s     <= '0;
      ys_s     <= '0;
      shift_s  <= '0;
      err_long <= 1'b0;
    end else begin
      if (vs_rise) begin
        y_cnt   <= '0;
        xs_s    <= x_start;
        ys_s    <= y_start;
        shift_s <= decim_shift(decim_sel);
      end else if (href_fall && y_cnt != '1) begin
        y_cnt <= y_cnt + 1'b1;
      end
      if (href_fall)                     x_cnt <= '0;
      else if (pix_valid && x_cnt != '1) x_cnt <= x_cnt + 1'b1;
      if (pix_valid && x_cnt >= SRC_W_C) err_long <= 1'b1;
    end
  end

  always_comb begin
    dx     = x_cnt - {2'b00, xs_s};
    dy     = y_cnt - {3'b000, ys_s};
    mask   = (CW'(1) << shift_s) - CW'(1);
    in_win = (x_cnt >= {2'b00, xs_s}) && (y_cnt >= {3'b000, ys_s}) &&
             ((dx & mask) == '0) && ((dy & mask) == '0) &&
             ((dx >> shift_s) < OUT_W_C) && ((dy >> shift_s) < OUT_H_C);
    keep   = (state == ST_CAPTURE) && pix_valid && in_win && !full && !vs_rise;
  end

  // Address is a running count of kept pixels; once the last location is
  // written, the full flag blocks any further strobes until the next frame.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      full   <= 1'b0;
      addr_q <= '0;
      dout_q <= '0;
      we_q   <= 1'b0;
    end else begin
      we_q <= keep;
      if (vs_rise) begin
        wr_ptr <= '0;
        full   <= 1'b0;
      end else if (keep) begin
        addr_q <= wr_ptr;
        dout_q <= pix;
        if (wr_ptr == LAST_ADDR) full <= 1'b1;
        else                     wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end

  assign fb.addr = addr_q;
  assign fb.dout = dout_q;
  assign fb.we   = we_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Mode seen at the closing vsync edge decides whether capture continues.
  always_comb begin
    state_nx  = state;
    frame_end = 1'b0;
    unique case (state)
      ST_IDLE:    if (mode == MODE_CONT || arm_edge) state_nx = ST_WAIT_VS;
      ST_WAIT_VS: if (vs_rise) state_nx = ST_CAPTURE;
      ST_CAPTURE: if (vs_rise) begin
        frame_end = 1'b1;
        state_nx  = (mode == MODE_SINGLE) ? ST_HOLD : ST_CAPTURE;
      end
      ST_HOLD:    if (arm_edge || mode == MODE_CONT) state_nx = ST_WAIT_VS;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  assign busy = (state == ST_CAPTURE);

endmodule

// File: tb/tb_ov7725_capture_ctrl.sv
// Directed-plus-random bench: drives whole sensor frames and compares every
// frame_buffer write against a frame-level model of crop and decimation.
module tb_ov7725_capture_ctrl;
  localparam int OUT_W     = 16;
  localparam int OUT_H     = 12;
  localparam int TB_ADDR_W = 8;
  localparam int SRC_W     = 40;
  localparam int NPIX      = OUT_W * OUT_H;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] d = 8'd0;
  logic       mode = 1'b0;
  logic       arm = 1'b0;
  logic [1:0] decim_sel = 2'd0;
  logic [9:0] x_start = 10'd0;
  logic [8:0] y_start = 9'd0;
  logic       busy, frame_done, err_odd, err_long;
  logic [7:0] frame_cnt;

  ov7725_capture_ctrl_if #(.ADDR_W(TB_ADDR_W)) fb_if ();

  ov7725_capture_ctrl #(
    .OUT_W(OUT_W), .OUT_H(OUT_H), .ADDR_W(TB_ADDR_W), .SRC_W(SRC_W)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .vsync(vsync), .href(href), .d(d),
    .mode(mode), .arm(arm), .decim_sel(decim_sel), .x_start(x_start),
    .y_start(y_start), .fb(fb_if), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .err_odd(err_odd), .err_long(err_long)
  );

  always #5 pclk = ~pclk;

  int checks = 0, passes = 0, fails = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int fd_cnt = 0, max_addr = 0;
  int exp_cnt = 0, exp_done = 0;
  bit prev_cap = 1'b0;
  int cur_dsel = 0, cur_xs = 0, cur_ys = 0;

  always @(negedge pclk) begin
    if (fb_if.we === 1'b1) begin
      got_q.push_back(32'({fb_if.addr, fb_if.dout}));
      if (int'(fb_if.addr) > max_addr) max_addr = int'(fb_if.addr);
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  function automatic logic [15:0] pixel_at(input logic [15:0] seed, input int x, input int y);
    return 16'(int'(seed) * 7 + x * 263 + y * 4099) ^ 16'(x << 11);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input int m, input int dsel, input int xs, input int ys);
    mode      = 1'(m);
    decim_sel = 2'(dsel);
    x_start   = 10'(xs);
    y_start   = 9'(ys);
    cur_dsel  = dsel;
    cur_xs    = xs;
    cur_ys    = ys;
  endtask

  // Expected writes for one captured frame, straight from the window rules.
  task automatic build_expected(input int w, input int h, input logic [15:0] seed);
    int dd, n;
    logic [TB_ADDR_W-1:0] a;
    dd = (cur_dsel == 0) ? 1 : (cur_dsel == 1) ? 2 : 4;
    n  = 0;
    exp_q.delete();
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (x >= cur_xs && y >= cur_ys && (x - cur_xs) % dd == 0 && (y - cur_ys) % dd == 0 &&
            (x - cur_xs) / dd < OUT_W && (y - cur_ys) / dd < OUT_H && n < NPIX) begin
          a = TB_ADDR_W'(n);
          exp_q.push_back(32'({a, pixel_at(seed, x, y)}));
          n++;
        end
      end
    end
  endtask

  task automatic send_frame(input int w, input int h, input logic [15:0] seed,
                            input int odd_line, input int arm_line, input int rst_line);
    int nbytes;
    logic [15:0] px;
    vsync = 1'b1;
    repeat (3) @(negedge pclk);
    vsync = 1'b0;
    repeat (4) @(negedge pclk);
    for (int y = 0; y < h; y++) begin
      nbytes = (y == odd_line) ? 2 * w + 1 : 2 * w;
      href = 1'b1;
      for (int b = 0; b < nbytes; b++) begin
        if (y == h / 2 && b == 0) begin
          decim_sel = 2'($urandom);
          x_start   = 10'($urandom);
          y_start   = 9'($urandom);
        end
        if (y == arm_line && b == 2) arm = 1'b1;
        if (y == arm_line && b == 6) arm = 1'b0;
        if (y == rst_line && b == w) begin
          rst_n = 1'b0;
          #1;
          check_output("rst_we", 32'(fb_if.we), 32'd0);
          check_output("rst_addr", 32'(fb_if.addr), 32'd0);
          check_output("rst_busy", 32'(busy), 32'd0);
          check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
          check_output("rst_err_odd", 32'(err_odd), 32'd0);
          check_output("rst_err_long", 32'(err_long), 32'd0);
          exp_cnt = 0;
        end
        if (y == rst_line && b == w + 2) rst_n = 1'b1;
        px = pixel_at(seed, b / 2, y);
        d  = (b % 2 == 0) ? px[15:8] : px[7:0];
        @(negedge pclk);
      end
      href = 1'b0;
      d    = 8'd0;
      repeat (6) @(negedge pclk);
    end
  endtask

  task automatic run_frame(input string tag, input bit captured, input int w, input int h,
                           input int odd_line, input int arm_line, input int rst_line);
    logic [15:0] seed;
    int n;
    seed = 16'($urandom);
    got_q.delete();
    if (prev_cap) begin
      exp_done++;
      exp_cnt = (exp_cnt + 1) % 256;
    end
    send_frame(w, h, seed, odd_line, arm_line, rst_line);
    exp_q.delete();
    if (captured) build_expected(w, h, seed);
    check_output({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_output({tag, "_write"}, got_q[i], exp_q[i]);
    check_output({tag, "_busy"}, 32'(busy), 32'(captured));
    check_output({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    check_output({tag, "_frame_done"}, 32'(fd_cnt), 32'(exp_done));
    prev_cap = captured;
  endtask

  initial begin
    repeat (3) @(negedge pclk);
    check_output("reset_we", 32'(fb_if.we), 32'd0);
    check_output("reset_addr", 32'(fb_if.addr), 32'd0);
    check_output("reset_dout", 32'(fb_if.dout), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_frame_done", 32'(frame_done), 32'd0);
    check_output("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    check_output("reset_err_odd", 32'(err_odd), 32'd0);
    check_output("reset_err_long", 32'(err_long), 32'd0);
    rst_n = 1'b1;
    apply_stimulus(0, 1, 0, 0);
    repeat (4) @(negedge pclk);

    $display("[TB] continuous capture, full and cropped windows");
    run_frame("cont_d2", 1'b1, 32, 24, -1, -1, -1);
    apply_stimulus(0, 0, 5, 3);
    run_frame("crop", 1'b1, 32, 20, -1, -1, -1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                     int'($urandom_range(0, 8)));
      run_frame("rand", 1'b1, int'($urandom_range(16, SRC_W)), int'($urandom_range(8, 24)),
                -1, -1, -1);
    end

    $display("[TB] framing errors");
    check_output("err_odd_clear", 32'(err_odd), 32'd0);
    check_output("err_long_clear", 32'(err_long), 32'd0);
    apply_stimulus(0, 1, 2, 1);
    run_frame("odd", 1'b1, 32, 24, 3, -1, -1);
    check_output("err_odd_set", 32'(err_odd), 32'd1);
    apply_stimulus(0, 0, 0, 0);
    run_frame("long", 1'b1, 45, 24, -1, -1, -1);
    check_output("err_long_set", 32'(err_long), 32'd1);
    check_output("err_odd_sticky", 32'(err_odd), 32'd1);
    check_output("addr_bound", 32'(max_addr <= NPIX - 1), 32'd1);

    $display("[TB] single-shot with arm");
    apply_stimulus(1, 1, 0, 0);
    run_frame("ss_arm", 1'b0, 32, 24, -1, 2, -1);
    apply_stimulus(1, 1, 0, 0);
    run_frame("ss_shot", 1'b1, 32, 24, -1, -1, -1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1, 1, 0, 0);
      run_frame("ss_hold", 1'b0, 32, 24, -1, -1, -1);
    end

    $display("[TB] resume and mid-frame reset");
    apply_stimulus(0, 1, 0, 0);
    run_frame("resume", 1'b1, 32, 24, -1, -1, -1);
    apply_stimulus(0, 0, 0, 8);
    run_frame("reset", 1'b0, 32, 24, -1, -1, 5);
    apply_stimulus(0, 2, 3, 2);
    run_frame("post_rst", 1'b1, 32, 24, -1, -1, -1);
    apply_stimulus(0, 1, 0, 0);
    run_frame("tail", 1'b1, 16, 4, -1, -1, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
